// File: rtl/queue_put_arbiter.sv
// queue_put_arbiter: round-robin two-producer put arbiter with full gating and flush sequencing
module queue_put_arbiter #(
  parameter int WIDTH = 12,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] d_in0,
  output logic             grant0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d_in1,
  output logic             grant1,
  input  logic             flush_req,
  input  logic             q_full,
  output logic             q_put,
  output logic [WIDTH-1:0] q_d_in,
  output logic             q_flush,
  output logic             busy
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(FLUSH_CYCLES - 1);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last, go, r0, r1, win0, win1;
  always_comb begin
    r0 = req0 & ~grant0;
    r1 = req1 & ~grant1;
    go = (state == IDLE) && !flush_req && !q_full;
    win0 = go & r0 & (~r1 | last);
    win1 = go & r1 & (~r0 | ~last);
    state_n = (state == IDLE) ? (flush_req ? FLUSH : IDLE)
                              : ((cnt == '0 && !flush_req) ? IDLE : FLUSH);
    cnt_n = (state == IDLE || cnt == '0) ? RELOAD : cnt - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= 1'b1;
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      q_put  <= 1'b0;
      q_d_in <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      grant0 <= win0;
      grant1 <= win1;
      q_put  <= win0 | win1;
      q_d_in <= win0 ? d_in0 : win1 ? d_in1 : q_d_in;
      last   <= win0 ? 1'b0 : win1 ? 1'b1 : last;
    end
  end
  assign q_flush = state == FLUSH;
  assign busy    = state == FLUSH;
endmodule

// File: tb/tb_queue_put_arbiter.sv
// tb_queue_put_arbiter: table-driven scoreboard bench for queue_put_arbiter
module tb_queue_put_arbiter;
  logic clk = 1'b0;
  logic rst, req0, req1, flush_req, q_full;
  logic grant0, grant1, q_put, q_flush, busy;
  logic [11:0] d_in0, d_in1, q_d_in;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  queue_put_arbiter #(.WIDTH(12), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .d_in0(d_in0), .grant0(grant0),
    .req1(req1), .d_in1(d_in1), .grant1(grant1),
    .flush_req(flush_req), .q_full(q_full),
    .q_put(q_put), .q_d_in(q_d_in), .q_flush(q_flush), .busy(busy)
  );
  typedef struct {
    logic rst, r0, r1, fl, full;
    logic [11:0] d0, d1;
    logic [16:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [16:0] sb[$];
  function automatic vec_t v(input logic rs, a, input logic [11:0] da, input logic b,
                             input logic [11:0] db, input logic f, fu, g0, g1, p, qf, bz,
                             input logic [11:0] qd);
    vec_t t;
    t.rst = rs;
    t.r0 = a;
    t.d0 = da;
    t.r1 = b;
    t.d1 = db;
    t.fl = f;
    t.full = fu;
    t.exp = {g0, g1, p, qf, bz, qd};
    return t;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; flush_req = 1'b0; q_full = 1'b0;
    d_in0 = '0; d_in1 = '0;
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(1,1,5,1,9,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(0,1,5,1,9,0,0, 1,0,1,0,0,5));
    vecs.push_back(v(0,1,5,1,9,0,0, 0,1,1,0,0,9));
    vecs.push_back(v(0,0,5,1,9,0,0, 0,0,0,0,0,9));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,9));
    vecs.push_back(v(0,1,1024,0,0,0,0, 1,0,1,0,0,1024));
    vecs.push_back(v(0,1,1024,0,0,0,0, 0,0,0,0,0,1024));
    vecs.push_back(v(0,0,1024,0,0,0,0, 0,0,0,0,0,1024));
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(0,1,5,1,9,0,0, 1,0,1,0,0,5));
    vecs.push_back(v(0,1,5,1,9,0,0, 0,1,1,0,0,9));
    vecs.push_back(v(0,1,5,1,9,0,0, 1,0,1,0,0,5));
    vecs.push_back(v(0,1,5,1,9,0,0, 0,1,1,0,0,9));
    vecs.push_back(v(0,1,5,1,9,0,0, 1,0,1,0,0,5));
    vecs.push_back(v(0,1,5,1,9,0,0, 0,1,1,0,0,9));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,9));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0,0,0,1,300,0,1, 0,0,0,0,0,9));
    vecs.push_back(v(0,0,0,1,300,0,0, 0,1,1,0,0,300));
    vecs.push_back(v(0,0,0,1,300,0,0, 0,0,0,0,0,300));
    vecs.push_back(v(0,1,7,1,300,0,1, 0,0,0,0,0,300));
    vecs.push_back(v(0,1,7,1,300,0,0, 1,0,1,0,0,7));
    vecs.push_back(v(0,0,7,1,300,0,0, 0,1,1,0,0,300));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,300));
    vecs.push_back(v(0,1,1024,0,0,1,0, 0,0,0,1,1,300));
    vecs.push_back(v(0,1,1024,0,0,0,0, 0,0,0,1,1,300));
    vecs.push_back(v(0,1,1024,0,0,0,0, 0,0,0,0,0,300));
    vecs.push_back(v(0,1,1024,0,0,0,0, 1,0,1,0,0,1024));
    vecs.push_back(v(0,1,1024,0,0,0,0, 0,0,0,0,0,1024));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,1024));
    vecs.push_back(v(0,0,0,0,0,1,0, 0,0,0,1,1,1024));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,1,1,1024));
    vecs.push_back(v(0,0,0,0,0,1,0, 0,0,0,1,1,1024));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,1,1,1024));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,1024));
    vecs.push_back(v(0,0,0,1,300,1,0, 0,0,0,1,1,1024));
    vecs.push_back(v(1,0,0,1,300,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,300,0,0, 0,1,1,0,0,300));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,300));
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req0 = vecs[i].r0;
      d_in0 = vecs[i].d0;
      req1 = vecs[i].r1;
      d_in1 = vecs[i].d1;
      flush_req = vecs[i].fl;
      q_full = vecs[i].full;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {grant0, grant1, q_put, q_flush, busy, q_d_in}, sb.pop_front());
      check($sformatf("onehot%0d", i), grant0 & grant1, 0);
      check($sformatf("put_eq%0d", i), q_put, grant0 | grant1);
    end
    rst = 1'b0; req0 = 1'b1; d_in0 = 12'd5; req1 = 1'b1; d_in1 = 12'd9;
    flush_req = 1'b1; q_full = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("flush_noput", q_put, 0);
      check("flush_busy", busy, 1);
    end
    flush_req = 1'b0;
    begin
      int n = 0;
      while (!q_put && n < 8) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("flush_wait", q_put, 1);
      check("flush_cycles", n, 3);
      check("flush_win", {grant0, grant1, q_d_in}, {2'b10, 12'd5});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
